// File: rtl/pack_cm_if.sv
// Bus bundle for the Saber cm packer: start/done control, shared-memory
// read port and the packed cm write port.
interface pack_cm_if;
    logic        start;
    logic        done;
    logic        read_base_sel;
    logic [8:0]  read_address;
    logic [63:0] read_data;
    logic [8:0]  write_address;
    logic [63:0] write_data;
    logic        write_en;

    // packer side
    modport slave (
        input  start,
        input  read_data,
        output done,
        output read_base_sel,
        output read_address,
        output write_address,
        output write_data,
        output write_en
    );

    // memory / controller side
    modport master (
        output start,
        output read_data,
        input  done,
        input  read_base_sel,
        input  read_address,
        input  write_address,
        input  write_data,
        input  write_en
    );
endinterface

// File: rtl/pack_cm.sv
// Saber encryption-side ciphertext packer.
// Reads 64 vprime words (four 10-bit lanes each) and 4 message words,
// computes cm = ((v + CM_ROUND - (m << 9)) mod 2^10) >> 6 per coefficient
// and writes 16 words of sixteen packed nibbles.
//
// state | meaning
// IDLE  | waiting for start after reset
// MADDR | message word address presented (bank 1)
// MLOAD | message word captured into m_buf
// VADDR | vprime word address presented (bank 0)
// VLOAD | vprime word captured into v_buf
// CALC  | four lanes packed into cm_buf, v_cnt advances
// WRITE | cm_buf written, write_address advances
// DONE  | run complete, holding results until start
module pack_cm #(
    parameter logic [9:0] CM_ROUND = 10'd0
) (
    input  logic      clk,
    input  logic      rst,
    pack_cm_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_MADDR, S_MLOAD, S_VADDR, S_VLOAD, S_CALC, S_WRITE, S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_v_cnt;
    logic [8:0]  r_wr_addr;
    logic [63:0] r_m_buf;
    logic [63:0] r_v_buf;
    logic [63:0] r_cm_buf;

    logic        w_sel;
    logic        w_we;
    logic        w_done;
    logic        w_clr;
    logic [9:0]  w_diff [4];
    logic [15:0] w_cm;
    logic        w_unused_lane_hi;

    // Lanes carry 10-bit coefficients in 16-bit slots; the top six bits are don't-care.
    assign w_unused_lane_hi = ^{r_v_buf[63:58], r_v_buf[47:42], r_v_buf[31:26], r_v_buf[15:10]};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode and per-state strobes.
    always_comb begin
        w_next = r_state;
        w_sel  = 1'b0;
        w_we   = 1'b0;
        w_done = 1'b0;
        w_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = S_MADDR;
                    w_clr  = 1'b1;
                end
            end
            S_MADDR: begin
                w_sel  = 1'b1;
                w_next = S_MLOAD;
            end
            S_MLOAD: begin
                w_sel  = 1'b1;
                w_next = S_VADDR;
            end
            S_VADDR: w_next = S_VLOAD;
            S_VLOAD: w_next = S_CALC;
            S_CALC:  w_next = (r_v_cnt[1:0] == 2'd3) ? S_WRITE : S_VADDR;
            S_WRITE: begin
                w_we = 1'b1;
                if (r_v_cnt == 9'd64)          w_next = S_DONE;
                else if (r_v_cnt[3:0] == 4'd0) w_next = S_MADDR;
                else                           w_next = S_VADDR;
            end
            S_DONE: begin
                w_done = 1'b1;
                if (bus.start) begin
                    w_next = S_MADDR;
                    w_clr  = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Per-lane rounding, message subtraction and truncation to 4 bits (all mod 2^10).
    always_comb begin
        w_cm = '0;
        for (int i = 0; i < 4; i++) begin
            w_diff[i] = r_v_buf[16*i +: 10] + CM_ROUND - {r_m_buf[i], 9'd0};
            w_cm[4*i +: 4] = w_diff[i][9:6];
        end
    end

    // Datapath: counters, operand buffers and the packing shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_cnt   <= '0;
            r_wr_addr <= '0;
            r_m_buf   <= '0;
            r_v_buf   <= '0;
            r_cm_buf  <= '0;
        end else begin
            if (w_clr) begin
                r_v_cnt   <= '0;
                r_wr_addr <= '0;
            end
            case (r_state)
                S_MLOAD: r_m_buf <= bus.read_data;
                S_VLOAD: r_v_buf <= bus.read_data;
                S_CALC: begin
                    r_cm_buf <= {w_cm, r_cm_buf[63:16]};
                    r_m_buf  <= r_m_buf >> 4;
                    r_v_cnt  <= r_v_cnt + 9'd1;
                end
                S_WRITE: r_wr_addr <= r_wr_addr + 9'd1;
                default: ;
            endcase
        end
    end

    assign bus.read_base_sel = w_sel;
    assign bus.read_address  = w_sel ? {4'd0, r_v_cnt[8:4]} : r_v_cnt;
    assign bus.write_address = r_wr_addr;
    assign bus.write_data    = r_cm_buf;
    assign bus.write_en      = w_we;
    assign bus.done          = w_done;

endmodule

// File: tb/tb_pack_cm.sv
// Directed bench for pack_cm: memory model, write/read monitors and
// per-run checks of data, addresses, pulse spacing and latency.
module tb_pack_cm;

    localparam logic [9:0] CM_ROUND = 10'd0;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pack_cm_if bus ();

    pack_cm #(.CM_ROUND(CM_ROUND)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] vmem [64];
    logic [63:0] mmem [4];
    logic [63:0] exp_w [16];

    int n_checks = 0;
    int n_fail   = 0;

    // memory: registered read, data valid the cycle after the address
    always @(posedge clk)
        bus.read_data <= bus.read_base_sel ? mmem[bus.read_address[1:0]]
                                           : vmem[bus.read_address[5:0]];

    logic [63:0] got_d [16];
    logic [8:0]  got_a [16];
    int          got_c [16];
    logic [8:0]  m_addr [8];
    int wr_cnt = 0, m_cnt = 0, wide_err = 0, hold_err = 0, gcyc = 0;
    logic prev_we = 1'b0, prev_sel = 1'b0;
    logic [8:0] last_maddr = '0;

    // monitor sampled on the falling edge
    always @(negedge clk) begin
        gcyc++;
        if (bus.write_en) begin
            if (wr_cnt < 16) begin
                got_d[wr_cnt] = bus.write_data;
                got_a[wr_cnt] = bus.write_address;
                got_c[wr_cnt] = gcyc;
            end
            wr_cnt++;
            if (prev_we) wide_err++;
        end
        prev_we = bus.write_en;
        if (bus.read_base_sel) begin
            if (!prev_sel) begin
                if (m_cnt < 8) m_addr[m_cnt] = bus.read_address;
                m_cnt++;
            end else if (bus.read_address != last_maddr) begin
                hold_err++;
            end
            last_maddr = bus.read_address;
        end
        prev_sel = bus.read_base_sel;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model_word(int j);
        logic [63:0] w;
        logic [9:0]  v, d;
        logic        m;
        int          n;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            n = 16*j + k;
            v = vmem[n/4][16*(n%4) +: 10];
            m = mmem[n/64][n%64];
            d = v + CM_ROUND - (m ? 10'd512 : 10'd0);
            w[4*k +: 4] = d[9:6];
        end
        return w;
    endfunction

    task automatic fill(input logic [63:0] v, input logic [63:0] m);
        for (int i = 0; i < 64; i++) vmem[i] = v;
        for (int i = 0; i < 4; i++)  mmem[i] = m;
    endtask

    // one full run; mid >= 0 pulses start that many cycles into the run
    task automatic run_case(input string tag, input int mid);
        int cyc;
        wr_cnt = 0; m_cnt = 0; wide_err = 0; hold_err = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_done_low"}, 64'(bus.done), 64'd0);
        check({tag, "_waddr_clr"}, 64'(bus.write_address), 64'd0);
        cyc = 0;
        while (!bus.done && cyc < 400) begin
            bus.start = (cyc == mid);
            @(posedge clk); #1;
            bus.start = 1'b0;
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd216);
        check({tag, "_waddr_end"}, 64'(bus.write_address), 64'd16);
        check({tag, "_wr_count"}, 64'(wr_cnt), 64'd16);
        check({tag, "_we_width"}, 64'(wide_err), 64'd0);
        check({tag, "_m_reads"}, 64'(m_cnt), 64'd4);
        check({tag, "_m_hold"}, 64'(hold_err), 64'd0);
        for (int i = 0; i < 4 && i < m_cnt; i++)
            check($sformatf("%s_m_addr%0d", tag, i), 64'(m_addr[i]), 64'(i));
        for (int j = 0; j < 16 && j < wr_cnt; j++) begin
            check($sformatf("%s_data%0d", tag, j), got_d[j], exp_w[j]);
            check($sformatf("%s_addr%0d", tag, j), 64'(got_a[j]), 64'(j));
            if (j > 0)
                check($sformatf("%s_gap%0d", tag, j), 64'(got_c[j] - got_c[j-1]),
                      (j % 4 == 0) ? 64'd15 : 64'd13);
        end
    endtask

    initial begin
        bus.start = 1'b0;
        fill('0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_we",    64'(bus.write_en), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);
        check("rst_waddr", 64'(bus.write_address), 64'd0);
        check("rst_sel",   64'(bus.read_base_sel), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        fill('0, '0);
        for (int j = 0; j < 16; j++) exp_w[j] = 64'h0;
        run_case("zero", -1);

        fill({4{16'h03FF}}, '0);
        for (int j = 0; j < 16; j++) exp_w[j] = 64'hFFFF_FFFF_FFFF_FFFF;
        run_case("vmax", -1);

        fill('0, '1);
        for (int j = 0; j < 16; j++) exp_w[j] = 64'h8888_8888_8888_8888;
        run_case("mones", -1);

        fill('0, '0);
        vmem[0] = 64'h0000_0000_0000_0040;
        mmem[0] = 64'h1;
        for (int j = 0; j < 16; j++) exp_w[j] = 64'h0;
        exp_w[0] = 64'h0000_0000_0000_0009;
        run_case("coef0", -1);

        for (int i = 0; i < 64; i++)
            for (int l = 0; l < 4; l++)
                vmem[i][16*l +: 16] = {6'd0, 10'($urandom_range(0, 1023))};
        for (int i = 0; i < 4; i++) mmem[i] = {$urandom, $urandom};
        for (int j = 0; j < 16; j++) exp_w[j] = model_word(j);
        run_case("rand", -1);

        // rerun from DONE with the same data; a mid-run start must be ignored
        run_case("rerun", 50);

        // reset partway through a run
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_we",    64'(bus.write_en), 64'd0);
        check("midrst_done",  64'(bus.done), 64'd0);
        check("midrst_waddr", 64'(bus.write_address), 64'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold_done", 64'(bus.done), 64'd0);
        check("idle_hold_sel",  64'(bus.read_base_sel), 64'd0);

        for (int i = 0; i < 4; i++) mmem[i] = {$urandom, $urandom};
        for (int j = 0; j < 16; j++) exp_w[j] = model_word(j);
        run_case("post_rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
